// File: rtl/fft_stream_radix2.sv
// Iterative radix-2 DIT FFT/IFFT: N real samples are loaded bit-reversed, transformed
// in place at one butterfly per cycle, then streamed out as N complex bins in natural order.
module fft_stream_radix2 #(
    parameter int LOG2N  = 3,
    parameter int DATA_W = 4,
    parameter int TW_W   = 8,
    parameter int OUT_W  = DATA_W + LOG2N + 1
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     inv,
    output logic signed [OUT_W-1:0]  out_re,
    output logic signed [OUT_W-1:0]  out_im,
    output logic [LOG2N-1:0]         out_index,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);
    localparam int N  = 1 << LOG2N;
    localparam int BW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N);
    localparam int PW = OUT_W + TW_W + 1;
    localparam int SH = 31 - TW_W;

    // cos(pi/8), cos(pi/4), sin(pi/8) held in Q1.30 and rounded down to Q1.(TW_W-1)
    localparam longint C1_30 = 64'sd992008094;
    localparam longint C2_30 = 64'sd759250125;
    localparam longint S1_30 = 64'sd410903207;
    localparam logic signed [TW_W-1:0] TC1 = TW_W'((C1_30 + (64'sd1 <<< (SH - 1))) >>> SH);
    localparam logic signed [TW_W-1:0] TC2 = TW_W'((C2_30 + (64'sd1 <<< (SH - 1))) >>> SH);
    localparam logic signed [TW_W-1:0] TS1 = TW_W'((S1_30 + (64'sd1 <<< (SH - 1))) >>> SH);
    localparam logic signed [PW-1:0]   RND = PW'(1) <<< (TW_W - 2);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

    state_t                  state;
    logic [LOG2N-1:0]        ld_cnt, out_cnt;
    logic [SW-1:0]           stage;
    logic [BW-1:0]           bfly;
    logic                    inv_r;
    logic signed [OUT_W-1:0] mem_re [N];
    logic signed [OUT_W-1:0] mem_im [N];

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    // Butterfly j of stage s: p = group base + k, q = p + 2^s, twiddle on the 16-point circle
    logic [LOG2N-1:0] addr_p, addr_q;
    logic [3:0]       m16;
    int unsigned      st, kk, base;

    always_comb begin
        st     = 32'(stage);
        kk     = 32'(bfly) & ((32'd1 << st) - 32'd1);
        base   = (32'(bfly) >> st) << (st + 32'd1);
        addr_p = LOG2N'(base | kk);
        addr_q = LOG2N'(base | kk | (32'd1 << st));
        m16    = 4'(kk << (32'd3 - st));
    end

    logic signed [TW_W-1:0]  tw_c, tw_s, w_re, w_im;
    logic signed [OUT_W-1:0] xp_re, xp_im, xq_re, xq_im, t_re, t_im;
    logic signed [OUT_W-1:0] sum_re, sum_im, dif_re, dif_im;
    logic signed [PW-1:0]    prod_re, prod_im;

    always_comb begin
        xp_re = mem_re[addr_p];
        xp_im = mem_im[addr_p];
        xq_re = mem_re[addr_q];
        xq_im = mem_im[addr_q];
        // Only the upper half circle is ever addressed; m=0 and m=4 never use the ROM
        case (m16)
            4'd1:    begin tw_c = TC1;  tw_s = TS1; end
            4'd2:    begin tw_c = TC2;  tw_s = TC2; end
            4'd3:    begin tw_c = TS1;  tw_s = TC1; end
            4'd5:    begin tw_c = -TS1; tw_s = TC1; end
            4'd6:    begin tw_c = -TC2; tw_s = TC2; end
            4'd7:    begin tw_c = -TC1; tw_s = TS1; end
            default: begin tw_c = '0;   tw_s = '0;  end
        endcase
        w_re    = tw_c;
        w_im    = inv_r ? tw_s : -tw_s;
        prod_re = PW'(xq_re) * PW'(w_re) - PW'(xq_im) * PW'(w_im) + RND;
        prod_im = PW'(xq_re) * PW'(w_im) + PW'(xq_im) * PW'(w_re) + RND;
        if (m16 == 4'd0) begin
            t_re = xq_re;
            t_im = xq_im;
        end else if (m16 == 4'd4) begin
            t_re = inv_r ? -xq_im : xq_im;
            t_im = inv_r ? xq_re  : -xq_re;
        end else begin
            t_re = OUT_W'(prod_re >>> (TW_W - 1));
            t_im = OUT_W'(prod_im >>> (TW_W - 1));
        end
        sum_re = xp_re + t_re;
        sum_im = xp_im + t_im;
        dif_re = xp_re - t_re;
        dif_im = xp_im - t_im;
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            state   <= S_LOAD;
            ld_cnt  <= '0;
            out_cnt <= '0;
            stage   <= '0;
            bfly    <= '0;
            inv_r   <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        mem_re[bitrev(ld_cnt)] <= OUT_W'(in_data);
                        mem_im[bitrev(ld_cnt)] <= '0;
                        if (ld_cnt == '0) inv_r <= inv;
                        ld_cnt <= ld_cnt + LOG2N'(1);
                        if (ld_cnt == LOG2N'(N - 1)) state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    mem_re[addr_p] <= sum_re;
                    mem_im[addr_p] <= sum_im;
                    mem_re[addr_q] <= dif_re;
                    mem_im[addr_q] <= dif_im;
                    if (bfly == BW'(N / 2 - 1)) begin
                        bfly <= '0;
                        if (stage == SW'(LOG2N - 1)) begin
                            stage <= '0;
                            state <= S_UNLOAD;
                        end else begin
                            stage <= stage + SW'(1);
                        end
                    end else begin
                        bfly <= bfly + BW'(1);
                    end
                end
                S_UNLOAD: begin
                    if (out_ready) begin
                        out_cnt <= out_cnt + LOG2N'(1);
                        if (out_cnt == LOG2N'(N - 1)) state <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    assign in_ready  = (state == S_LOAD);
    assign busy      = (state != S_LOAD);
    assign out_valid = (state == S_UNLOAD);
    assign out_re    = out_valid ? mem_re[out_cnt] : '0;
    assign out_im    = out_valid ? mem_im[out_cnt] : '0;
    assign out_index = out_valid ? out_cnt : '0;
    assign out_last  = out_valid && (out_cnt == LOG2N'(N - 1));

endmodule

// File: doc/fft_stream_radix2.md
Name: fft_stream_radix2

Overview:
- Parametrised iterative radix-2 decimation-in-time FFT/IFFT engine.
- Accepts a frame of N real signed samples over a valid/ready stream and computes in place with one butterfly per cycle.
- Streams out N complex bins in natural order with valid/ready backpressure.
- Successor to the fixed 8-point serial FFT. Adds selectable N, data width, inverse mode and flow control, and replaces sel/sel_1 external sequencing with an internal FSM.

Parameters:
- LOG2N, 3, log2 of point count; legal values 2, 3, 4 (N = 4, 8, 16).
- DATA_W, 4, signed input sample width.
- TW_W, 8, signed twiddle width, Q1.(TW_W-1).
- OUT_W, DATA_W+LOG2N+1, output/internal component width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- in_data  in  DATA_W  signed real input sample.
- in_valid  in  1  sample present.
- in_ready  out  1  high only in LOAD.
- inv  in  1  0 = forward FFT, 1 = inverse (conjugated twiddles, no 1/N scaling).
- out_re  out  OUT_W  signed real part of bin.
- out_im  out  OUT_W  signed imaginary part of bin.
- out_index  out  LOG2N  bin number of the current output.
- out_last  out  1  high with bin N-1.
- out_valid  out  1  bin present.
- out_ready  in  1  downstream accepts.
- busy  out  1  high in COMPUTE or UNLOAD.

Behaviour:
- Reset (clear=0 at a clk edge), from any state, including mid-frame:
  - state := LOAD; all counters := 0.
  - out_valid, out_last, out_re, out_im, out_index, busy := 0.
  - in_ready = 1 from the first cycle after reset.
  - Partial frame data is discarded; memory contents are don't-care.
- FSM states: LOAD -> COMPUTE -> UNLOAD -> LOAD.
- LOAD:
  - A sample is accepted on an edge with in_valid && in_ready.
  - Sample n (arrival order 0..N-1) is sign-extended to OUT_W and stored at bit-reversed address rev(n) as re; im := 0.
  - inv is latched with sample 0 and held for the whole frame. Changes after sample 0 are ignored.
  - Accepting sample N-1 moves to COMPUTE; in_ready drops the next cycle.
- COMPUTE:
  - Exactly LOG2N*N/2 cycles; one butterfly per cycle.
  - Stage s = 0..LOG2N-1, span h = 2^s, butterfly j = 0..N/2-1.
  - Addresses: p = group base + k, q = p + h, with twiddle index k*(N/(2h)) on the N-point circle.
  - Butterfly: t = W*X[q]; X[p] := X[p] + t; X[q] := X[p] - t, using the pre-update X[p].
  - Operands are read combinationally and written back on the same edge.
- Twiddles:
  - W = cos(2πm/N) - i·sin(2πm/N) for forward; the conjugate for inverse.
  - Constants are stored as round(value·2^(TW_W-1)).
  - m = 0 is an exact bypass (multiply by 1), so X[q] passes unchanged.
  - m = N/4 is an exact ±i swap with negation; no multiply.
  - Twiddle table is a 16-entry-circle case ROM; N=4 and N=8 index it with stride 16/N.
- Products:
  - Full-precision complex product, then rounded: add 2^(TW_W-2), arithmetic shift right by TW_W-1, truncate to OUT_W.
  - Sums wrap in OUT_W. Wrap cannot occur for in-range inputs: |bin| ≤ N·2^(DATA_W-1).
- UNLOAD:
  - Bins are presented in natural order 0..N-1, read from address k.
  - out_valid = 1. out_re, out_im, out_index and out_last are held stable while out_valid && !out_ready.
  - Advance on out_valid && out_ready.
  - The handshake on bin N-1 (out_last=1) returns to LOAD; out_valid drops the next cycle and in_ready rises the same cycle.
- busy = 1 in COMPUTE and UNLOAD.
- in_valid outside LOAD is ignored; no buffering of early samples.
- out_ready outside UNLOAD is ignored.
- Minimum frame period with continuous handshakes: N + LOG2N·N/2 + N cycles (N=8: 28).
- Throughput: a new frame cannot be loaded until UNLOAD completes.

Test Plan:
- N=8, DATA_W=4, forward; input 4,1,2,3,1,2,0,4 with in_valid held high:
  - in_ready low exactly 12 compute cycles after sample 7.
  - Bin0 = (17, 0); bin4 = (-3, 0).
  - Remaining bins within ±1 LSB per component of the double-precision DFT.
  - out_last only with index 7.
- Impulse: x = 5,0,0,0,0,0,0,0 -> all 8 bins = (5, 0), forward and inverse.
- DC: all samples = -8 (N=8) -> bin0 = (-64, 0), bins 1..7 = (0, 0). No wrap in OUT_W = 8.
- Backpressure: out_ready toggled 1,0,0,1,... during UNLOAD -> each bin held stable while stalled; indices 0..7 in order with no repeats or skips. in_valid pulses during COMPUTE are not accepted.
- Reset mid-operation: clear=0 for one cycle after 5 samples loaded, and again mid-COMPUTE -> outputs zero, in_ready=1 next cycle; a following full frame gives the correct result.
- LOG2N=4, DATA_W=6: alternating +31,-31 -> bin8 = (496, 0), all others (0, 0). Inverse mode: bin0 of input 1,0,...,0 = (1, 0).
